// File: rtl/tlb_refill_ctrl.sv
// TLB miss refill controller: victim select via tree-PLRU, PTW walk, entry write, MRU update.
// Optional PTW timeout is enabled by defining TLB_REFILL_TIMEOUT_EN.
module tlb_refill_ctrl #(
  parameter int unsigned ENTRIES   = 32,
  parameter int unsigned IDX_W     = 5,
  parameter int unsigned VPN_W     = 20,
  parameter int unsigned PTE_W     = 32,
  parameter int unsigned TO_CYCLES = 256
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             miss_valid_i,
  input  logic [VPN_W-1:0] miss_vpn_i,
  output logic             miss_ready_o,
  input  logic             flush_i,
  input  logic             hit_access_i,
  input  logic [IDX_W-1:0] hit_idx_i,
  output logic             lru_compare_o,
  input  logic [IDX_W-1:0] lru_addr_i,
  output logic             lru_access_o,
  output logic [IDX_W-1:0] lru_access_addr_o,
  output logic             ptw_req_valid_o,
  output logic [VPN_W-1:0] ptw_req_vpn_o,
  input  logic             ptw_req_ready_i,
  input  logic             ptw_resp_valid_i,
  input  logic [PTE_W-1:0] ptw_resp_pte_i,
  input  logic             ptw_resp_fault_i,
  output logic             tlb_wr_en_o,
  output logic [IDX_W-1:0] tlb_wr_idx_o,
  output logic [VPN_W-1:0] tlb_wr_vpn_o,
  output logic [PTE_W-1:0] tlb_wr_pte_o,
  output logic             done_valid_o,
  output logic             done_fault_o,
  output logic [IDX_W-1:0] done_idx_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_VICTIM, S_CAPTURE, S_PTW_REQ, S_PTW_WAIT, S_WRITE, S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [VPN_W-1:0] vpn_q, vpn_d;
  logic [IDX_W-1:0] victim_q, victim_d;
  logic [PTE_W-1:0] pte_q, pte_d;
  logic             fault_q, fault_d;
  logic             stale_q, stale_d;
  logic             handshake;
  logic             timeout;

  // A request only leaves while no discarded response is still owed by the PTW.
  assign handshake = (state_q == S_PTW_REQ) && !stale_q && ptw_req_ready_i;

`ifdef TLB_REFILL_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TO_CYCLES) > 8) ? $clog2(TO_CYCLES) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign cnt_d   = (state_q == S_PTW_WAIT) ? cnt_q + 1'b1 : '0;
  assign timeout = (state_q == S_PTW_WAIT) && (cnt_q == CNT_W'(TO_CYCLES - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      vpn_q    <= '0;
      victim_q <= '0;
      pte_q    <= '0;
      fault_q  <= 1'b0;
      stale_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      vpn_q    <= vpn_d;
      victim_q <= victim_d;
      pte_q    <= pte_d;
      fault_q  <= fault_d;
      stale_q  <= stale_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:     if (miss_valid_i) state_d = S_VICTIM;
      S_VICTIM:   state_d = S_CAPTURE;
      S_CAPTURE:  state_d = S_PTW_REQ;
      S_PTW_REQ:  if (handshake) state_d = S_PTW_WAIT;
      S_PTW_WAIT: begin
        if (ptw_resp_valid_i) state_d = ptw_resp_fault_i ? S_DONE : S_WRITE;
        else if (timeout)     state_d = S_DONE;
      end
      S_WRITE:    state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
    if (flush_i && (state_q != S_IDLE) && (state_q != S_DONE)) state_d = S_IDLE;
  end

  always_comb begin
    vpn_d    = vpn_q;
    victim_d = victim_q;
    pte_d    = pte_q;
    fault_d  = fault_q;
    stale_d  = stale_q;
    if (state_q == S_IDLE && miss_valid_i) begin
      vpn_d   = miss_vpn_i;
      fault_d = 1'b0;
    end
    if (state_q == S_CAPTURE) victim_d = lru_addr_i;
    if (state_q == S_PTW_WAIT) begin
      if (ptw_resp_valid_i) begin
        if (ptw_resp_fault_i) fault_d = 1'b1;
        else                  pte_d   = ptw_resp_pte_i;
      end else if (timeout) begin
        fault_d = 1'b1;
        stale_d = 1'b1;
      end
    end
    if (stale_q && ptw_resp_valid_i) stale_d = 1'b0;
    // Abandoning an issued walk leaves its response outstanding; one arriving now is simply dropped.
    if (flush_i && (handshake || (state_q == S_PTW_WAIT && !ptw_resp_valid_i))) stale_d = 1'b1;
  end

  always_comb begin
    miss_ready_o      = (state_q == S_IDLE);
    lru_compare_o     = (state_q == S_VICTIM);
    ptw_req_valid_o   = (state_q == S_PTW_REQ) && !stale_q;
    ptw_req_vpn_o     = vpn_q;
    tlb_wr_en_o       = (state_q == S_WRITE);
    tlb_wr_idx_o      = victim_q;
    tlb_wr_vpn_o      = vpn_q;
    tlb_wr_pte_o      = pte_q;
    lru_access_o      = (state_q == S_WRITE) || hit_access_i;
    lru_access_addr_o = (state_q == S_WRITE) ? victim_q : hit_idx_i;
    done_valid_o      = (state_q == S_DONE);
    done_fault_o      = (state_q == S_DONE) && fault_q;
    done_idx_o        = (state_q == S_DONE && !fault_q) ? victim_q : '0;
  end

endmodule

// File: tb/tb_tlb_refill_ctrl.sv
// Bench for tlb_refill_ctrl: plays LRU and PTW, predicts every output from the refill
// transaction description (victim, delays, fault, flush point) and checks each cycle.
module tb_tlb_refill_ctrl;
  localparam int IDX_W = 5;
  localparam int VPN_W = 20;
  localparam int PTE_W = 32;
`ifdef TLB_REFILL_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 256;
`endif

  logic             clk, rst;
  logic             miss_valid, miss_ready, flush, hit_access, lru_compare, lru_access;
  logic [VPN_W-1:0] miss_vpn, ptw_req_vpn, tlb_wr_vpn;
  logic [IDX_W-1:0] hit_idx, lru_addr, lru_access_addr, tlb_wr_idx, done_idx;
  logic             ptw_req_valid, ptw_req_ready, ptw_resp_valid, ptw_resp_fault;
  logic [PTE_W-1:0] ptw_resp_pte, tlb_wr_pte;
  logic             tlb_wr_en, done_valid, done_fault;

  tlb_refill_ctrl #(.ENTRIES(32), .IDX_W(IDX_W), .VPN_W(VPN_W), .PTE_W(PTE_W), .TO_CYCLES(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .miss_valid_i(miss_valid), .miss_vpn_i(miss_vpn), .miss_ready_o(miss_ready),
    .flush_i(flush), .hit_access_i(hit_access), .hit_idx_i(hit_idx),
    .lru_compare_o(lru_compare), .lru_addr_i(lru_addr),
    .lru_access_o(lru_access), .lru_access_addr_o(lru_access_addr),
    .ptw_req_valid_o(ptw_req_valid), .ptw_req_vpn_o(ptw_req_vpn), .ptw_req_ready_i(ptw_req_ready),
    .ptw_resp_valid_i(ptw_resp_valid), .ptw_resp_pte_i(ptw_resp_pte), .ptw_resp_fault_i(ptw_resp_fault),
    .tlb_wr_en_o(tlb_wr_en), .tlb_wr_idx_o(tlb_wr_idx), .tlb_wr_vpn_o(tlb_wr_vpn), .tlb_wr_pte_o(tlb_wr_pte),
    .done_valid_o(done_valid), .done_fault_o(done_fault), .done_idx_o(done_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  bit             e_ready, e_cmp, e_preq, e_wr, e_done, e_fault;
  logic [IDX_W-1:0] e_idx;
  logic [VPN_W-1:0] e_vpn;
  logic [PTE_W-1:0] e_pte;
  bit             rnd_hit = 1'b0;
  bit             stale_m = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_exp(input bit rdy, input bit cmp, input bit preq, input bit wr, input bit dn, input bit flt);
    e_ready = rdy; e_cmp = cmp; e_preq = preq; e_wr = wr; e_done = dn; e_fault = flt;
  endtask

  // Called just after a falling edge with inputs already set; checks, then advances one cycle.
  task automatic cyc();
    if (rnd_hit) begin
      hit_access = 1'($urandom_range(0, 1));
      hit_idx    = IDX_W'($urandom);
    end
    #1;
    chk("miss_ready", miss_ready, e_ready);
    chk("lru_compare", lru_compare, e_cmp);
    chk("ptw_req_valid", ptw_req_valid, e_preq);
    if (e_preq) chk("ptw_req_vpn", ptw_req_vpn, e_vpn);
    chk("tlb_wr_en", tlb_wr_en, e_wr);
    if (e_wr) begin
      chk("tlb_wr_idx", tlb_wr_idx, e_idx);
      chk("tlb_wr_vpn", tlb_wr_vpn, e_vpn);
      chk("tlb_wr_pte", tlb_wr_pte, e_pte);
    end
    chk("lru_access", lru_access, e_wr | hit_access);
    chk("lru_access_addr", lru_access_addr, e_wr ? e_idx : hit_idx);
    chk("done_valid", done_valid, e_done);
    if (e_done) begin
      chk("done_fault", done_fault, e_fault);
      chk("done_idx", done_idx, e_fault ? '0 : e_idx);
    end
    @(negedge clk);
  endtask

  task automatic after_flush();
    flush = 1'b0;
    set_exp(1, 0, 0, 0, 0, 0);
    cyc();
  endtask

  // fl: 0 none, 1 VICTIM, 2 CAPTURE, 3 PTW_REQ not-ready, 4 PTW_REQ ready cycle,
  //     5 PTW_WAIT idle, 6 PTW_WAIT with response, 7 DONE, 8 reset in PTW_WAIT, 9 timeout
  task automatic refill(input logic [VPN_W-1:0] vpn, input logic [IDX_W-1:0] vic, input int rdly,
                        input int wdly, input bit flt, input logic [PTE_W-1:0] pte, input int fl);
    e_vpn = vpn; e_idx = vic; e_pte = pte;
    miss_valid = 1'b1; miss_vpn = vpn;
    set_exp(1, 0, 0, 0, 0, 0);
    cyc();
    miss_valid = 1'b0; miss_vpn = VPN_W'($urandom);

    set_exp(0, 1, 0, 0, 0, 0);
    flush = (fl == 1);
    cyc();
    if (fl == 1) begin after_flush(); return; end

    lru_addr = vic;
    set_exp(0, 0, 0, 0, 0, 0);
    flush = (fl == 2);
    cyc();
    lru_addr = '0;
    if (fl == 2) begin after_flush(); return; end

    if (stale_m) begin
      repeat ($urandom_range(0, 3)) begin
        ptw_req_ready = 1'($urandom_range(0, 1));
        cyc();
      end
      ptw_resp_valid = 1'b1; ptw_resp_pte = $urandom; ptw_resp_fault = 1'($urandom_range(0, 1));
      ptw_req_ready = 1'($urandom_range(0, 1));
      cyc();
      ptw_resp_valid = 1'b0; ptw_resp_fault = 1'b0; ptw_req_ready = 1'b0;
      stale_m = 1'b0;
    end

    for (int d = 0; d <= rdly; d++) begin
      ptw_req_ready = (d == rdly);
      set_exp(0, 0, 1, 0, 0, 0);
      flush = (fl == 3 && d == 0) || (fl == 4 && d == rdly);
      cyc();
      ptw_req_ready = 1'b0;
      if (flush) begin
        if (fl == 4) stale_m = 1'b1;
        after_flush();
        return;
      end
    end

    set_exp(0, 0, 0, 0, 0, 0);
`ifdef TLB_REFILL_TIMEOUT_EN
    if (fl == 9) begin
      repeat (TO) cyc();
      set_exp(0, 0, 0, 0, 1, 1);
      cyc();
      stale_m = 1'b1;
      set_exp(1, 0, 0, 0, 0, 0);
      cyc();
      return;
    end
`endif
    for (int d = 0; d < wdly; d++) begin
      if (fl == 8 && d == 0) begin
        rst = 1'b1;
        set_exp(1, 0, 0, 0, 0, 0);
        cyc();
        rst = 1'b0;
        stale_m = 1'b0;
        after_flush();
        return;
      end
      flush = (fl == 5 && d == 0);
      cyc();
      if (flush) begin stale_m = 1'b1; after_flush(); return; end
    end

    ptw_resp_valid = 1'b1; ptw_resp_pte = pte; ptw_resp_fault = flt;
    flush = (fl == 6);
    cyc();
    ptw_resp_valid = 1'b0; ptw_resp_fault = 1'b0; ptw_resp_pte = $urandom;
    if (fl == 6) begin after_flush(); return; end

    if (!flt) begin
      set_exp(0, 0, 0, 1, 0, 0);
      cyc();
    end
    set_exp(0, 0, 0, 0, 1, flt);
    flush = (fl == 7);
    cyc();
    flush = 1'b0;
    set_exp(1, 0, 0, 0, 0, 0);
    cyc();
  endtask

  // Idle cycles with stray flushes and PTW responses, none of which may disturb the controller.
  task automatic idle_gap(input int n);
    set_exp(1, 0, 0, 0, 0, 0);
    repeat (n) begin
      flush = 1'($urandom_range(0, 1));
      ptw_resp_valid = 1'($urandom_range(0, 3) == 0);
      ptw_resp_fault = 1'($urandom_range(0, 1));
      ptw_resp_pte = $urandom;
      if (ptw_resp_valid) stale_m = 1'b0;
      cyc();
      flush = 1'b0; ptw_resp_valid = 1'b0; ptw_resp_fault = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; miss_valid = 1'b0; miss_vpn = '0; flush = 1'b0; hit_access = 1'b0; hit_idx = '0;
    lru_addr = '0; ptw_req_ready = 1'b0; ptw_resp_valid = 1'b0; ptw_resp_pte = '0; ptw_resp_fault = 1'b0;
    e_idx = '0; e_vpn = '0; e_pte = '0;
    @(negedge clk);
    set_exp(1, 0, 0, 0, 0, 0);
    cyc();
    chk("rst_ptw_req_vpn", ptw_req_vpn, 0);
    chk("rst_tlb_wr_idx", tlb_wr_idx, 0);
    chk("rst_tlb_wr_pte", tlb_wr_pte, 0);
    chk("rst_done_idx", done_idx, 0);
    rst = 1'b0;
    cyc();

    refill(20'h12345, 5'd7, 0, 0, 1'b0, 32'hA5A5_0001, 0);
    refill(20'h00ABC, 5'd12, 0, 0, 1'b1, 32'h1234_5678, 0);
    hit_access = 1'b1; hit_idx = 5'd3;
    refill(20'h0F00D, 5'd9, 1, 1, 1'b0, 32'h0BAD_F00D, 0);
    cyc();
    hit_access = 1'b0;
    refill(20'h00777, 5'd21, 0, 2, 1'b0, 32'h7777_0000, 5);
    refill(20'h00002, 5'd4, 0, 0, 1'b0, 32'h0000_2002, 0);
    refill(20'h55555, 5'd30, 5, 0, 1'b0, 32'h5555_AAAA, 0);
    refill(20'h01234, 5'd1, 0, 2, 1'b0, 32'h0, 8);
    refill(20'h04321, 5'd2, 0, 0, 1'b0, 32'h4321_0000, 0);
`ifdef TLB_REFILL_TIMEOUT_EN
    refill(20'h0DEAD, 5'd17, 0, 0, 1'b0, 32'h0, 9);
    idle_gap(3);
    refill(20'h0BEEF, 5'd18, 0, 1, 1'b0, 32'hBEEF_0001, 0);
`endif

    rnd_hit = 1'b1;
    for (int i = 0; i < 160; i++) begin
      int fl, rd, wd;
      fl = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 8));
      rd = int'($urandom_range(0, 3));
      wd = int'($urandom_range(0, 4));
      if (fl == 3 && rd == 0) rd = 1;
      if ((fl == 5 || fl == 8) && wd == 0) wd = 1;
      refill(VPN_W'($urandom), IDX_W'($urandom), rd, wd, 1'($urandom_range(0, 3) == 0), $urandom, fl);
      idle_gap(int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
